armleocpu_mul_seq: RTL



---
 rtl/armleocpu_mul_seq_pkg.sv | 27 ++
 rtl/armleocpu_mul_pp.sv | 52 +++++
 rtl/armleocpu_mul_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/armleocpu_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// armleocpu_mul_seq_pkg
// Shared definitions for the sequential multiplier:
//   - mul_op_t    : RV M-extension multiply operation encodings
//   - mul_state_t : multiplier FSM state encodings
// -----------------------------------------------------------------------------
package armleocpu_mul_seq_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OP   = 2'b01,
        ST_FIN  = 2'b10
    } mul_state_t;

    // Width of a counter/index able to hold values 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/armleocpu_mul_pp.sv
// -----------------------------------------------------------------------------
// armleocpu_mul_pp
// Combinational partial-product generator for one step of the sequential
// multiplier. For step k it selects chunk i = k % M of operand a and chunk
// j = k / M of operand b, multiplies them with a single CHUNKxCHUNK multiplier
// and shifts the product to its weight (i+j)*CHUNK in a 2*XLEN-bit word.
// Ports:
//   a   in  XLEN              unsigned magnitude of operand 0
//   b   in  XLEN              unsigned magnitude of operand 1
//   k   in  clog2(M*M)        step index
//   pp  out 2*XLEN            shifted partial product
// -----------------------------------------------------------------------------
module armleocpu_mul_pp
    import armleocpu_mul_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 16,
    parameter int KW    = 2
) (
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [KW-1:0]     k,
    output logic [2*XLEN-1:0] pp
);

    localparam int M  = XLEN / CHUNK;
    localparam int MW = idx_width(M);

    logic [CHUNK-1:0]   a_chunk [M];
    logic [CHUNK-1:0]   b_chunk [M];
    logic [MW-1:0]      i_idx;
    logic [MW-1:0]      j_idx;
    logic [2*CHUNK-1:0] prod;
    int                 shamt;

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_chunk
            assign a_chunk[gi] = a[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b[gi*CHUNK +: CHUNK];
        end
    endgenerate

    always_comb begin
        // a chunk index runs fastest, b chunk index slowest
        i_idx = MW'(k % KW'(M));
        j_idx = MW'(k / KW'(M));
        prod  = (2*CHUNK)'(a_chunk[i_idx]) * (2*CHUNK)'(b_chunk[j_idx]);
        shamt = (int'(i_idx) + int'(j_idx)) * CHUNK;
        pp    = (2*XLEN)'(prod) << shamt;
    end

endmodule

// File: rtl/armleocpu_mul_seq.sv
// -----------------------------------------------------------------------------
// armleocpu_mul_seq
// Sequential integer multiplier for the execute stage. One CHUNKxCHUNK
// multiplier is iterated over all M*M chunk pairs of the operand magnitudes;
// sign is applied once at the end. Supports MUL, MULH, MULHSU and MULHU.
// Ports:
//   clk          in   1       clock
//   rst_n        in   1       synchronous active-low reset
//   kill         in   1       abort in-flight op, return to IDLE
//   in_valid     in   1       request valid
//   in_ready     out  1       high iff idle
//   op           in   2       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   factor0      in   XLEN    rs1 operand
//   factor1      in   XLEN    rs2 operand
//   out_valid    out  1       single-cycle result strobe
//   result       out  XLEN    low half for MUL, high half otherwise
//   result_full  out  2*XLEN  full product
// -----------------------------------------------------------------------------
module armleocpu_mul_seq
    import armleocpu_mul_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kill,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   factor0,
    input  logic [XLEN-1:0]   factor1,
    output logic              out_valid,
    output logic [XLEN-1:0]   result,
    output logic [2*XLEN-1:0] result_full
);

    localparam int M  = XLEN / CHUNK;
    localparam int N  = M * M;
    localparam int KW = idx_width(N);

    mul_state_t        state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    mul_op_t           op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] result_full_q, result_full_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic              last_step;
    logic [2*XLEN-1:0] pp;
    logic              f0_neg;
    logic              f1_neg;

    armleocpu_mul_pp #(
        .XLEN  (XLEN),
        .CHUNK (CHUNK),
        .KW    (KW)
    ) u_pp (
        .a  (a_q),
        .b  (b_q),
        .k  (k_q),
        .pp (pp)
    );

    assign last_step = (k_q == KW'(N - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept)    state_d = ST_OP;
                ST_OP:   if (last_step) state_d = ST_FIN;
                ST_FIN:                 state_d = ST_IDLE;
                default:                state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        accept   = in_ready && in_valid && !kill;
    end

    // ---------------- Datapath ----------------
    always_comb begin
        // Sign of each operand only matters for the signed flavours.
        f0_neg = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && factor0[XLEN-1];
        f1_neg = (op == MUL_OP_MULH) && factor1[XLEN-1];

        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        neg_d         = neg_q;
        acc_d         = acc_q;
        k_d           = k_q;
        result_full_d = result_full_q;
        result_d      = result_q;
        out_valid_d   = 1'b0;

        // kill freezes everything except the FSM and suppresses out_valid
        if (!kill) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_d  = mul_op_t'(op);
                        // Two's-complement negate of the most negative value
                        // yields the same bit pattern, which read unsigned is
                        // exactly its magnitude.
                        a_d   = f0_neg ? (XLEN'(0) - factor0) : factor0;
                        b_d   = f1_neg ? (XLEN'(0) - factor1) : factor1;
                        neg_d = f0_neg ^ f1_neg;
                        acc_d = '0;
                        k_d   = '0;
                    end
                end
                ST_OP: begin
                    acc_d = acc_q + pp;
                    k_d   = last_step ? '0 : (k_q + KW'(1));
                end
                ST_FIN: begin
                    // -0 == 0, so a zero product never becomes nonzero
                    result_full_d = neg_q ? ((2*XLEN)'(0) - acc_q) : acc_q;
                    result_d      = (op_q == MUL_OP_MUL) ? result_full_d[XLEN-1:0]
                                                         : result_full_d[2*XLEN-1:XLEN];
                    out_valid_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q           <= '0;
            op_q          <= MUL_OP_MUL;
            a_q           <= '0;
            b_q           <= '0;
            neg_q         <= 1'b0;
            acc_q         <= '0;
            result_full_q <= '0;
            result_q      <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            k_q           <= k_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            neg_q         <= neg_d;
            acc_q         <= acc_d;
            result_full_q <= result_full_d;
            result_q      <= result_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_full = result_full_q;

endmodule
